// File: rtl/usb_dev_rw_responder_if.sv
// ---------------------------------------------------------------------------
// usb_dev_rw_responder_if
//
// Groups the three buses that the read/write responder touches:
//   rx_*      decoded packet from the device packet decoder
//   tx_*      request to / completion from the device packet transmitter
//   mem_*     single-port access to the device-side 64-bit memory
//
// Modports:
//   master  environment side (decoder, transmitter, memory)
//   slave   responder side (usb_dev_rw_responder)
// ---------------------------------------------------------------------------
interface usb_dev_rw_responder_if;
    // receive side
    logic        rx_valid;
    logic [3:0]  rx_pid;
    logic [6:0]  rx_addr;
    logic [3:0]  rx_endp;
    logic [63:0] rx_data;
    logic        rx_crc_ok;

    // transmit side
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [63:0] tx_data;
    logic        tx_done;

    // memory side
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [63:0] mem_rdata;
    logic        mem_wr_en;
    logic [63:0] mem_wdata;

    modport master (
        output rx_valid, rx_pid, rx_addr, rx_endp, rx_data, rx_crc_ok,
        output tx_done, mem_rdata,
        input  tx_start, tx_pid, tx_data,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_pid, rx_addr, rx_endp, rx_data, rx_crc_ok,
        input  tx_done, mem_rdata,
        output tx_start, tx_pid, tx_data,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/usb_dev_rw_responder.sv
// ---------------------------------------------------------------------------
// usb_dev_rw_responder
//
// Device-side responder for the page-addressed read/write protocol. An OUT
// token plus DATA0 loads a 16-bit page; the next token picks the operation:
// IN reads the memory word at that page and returns it in DATA0, OUT writes
// the following DATA0 payload to that page.
//
// Ports:
//   clk         clock
//   rst_b       asynchronous active-low reset
//   bus         rx / tx / mem buses (slave modport)
//   xfer_done   one-cycle pulse when a read or write completes
//   xfer_write  qualifies xfer_done: 1 = write, 0 = read
//   busy        high whenever a sequence is in progress
// ---------------------------------------------------------------------------
module usb_dev_rw_responder #(
    parameter logic [6:0] DEV_ADDR = 7'd5,
    parameter logic [3:0] ENDP     = 4'd4,
    parameter int         TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_b,
    usb_dev_rw_responder_if.slave bus,
    output logic                  xfer_done,
    output logic                  xfer_write,
    output logic                  busy
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    localparam int             TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD_DATA,
        PAGE_WAIT,
        WR_DATA,
        RD_FETCH,
        RD_TX,
        RD_ACK,
        ACK_TX
    } state_t;

    state_t        state_reg, state_next;
    logic [15:0]   page_reg, page_next;
    logic          tx_start_reg, tx_start_next;
    logic [3:0]    tx_pid_reg, tx_pid_next;
    logic [63:0]   tx_data_reg, tx_data_next;
    logic          rd_capture_reg, rd_capture_next;
    logic          mem_rd_en_reg, mem_rd_en_next;
    logic          mem_wr_en_reg, mem_wr_en_next;
    logic [63:0]   mem_wdata_reg, mem_wdata_next;
    logic          xfer_done_reg, xfer_done_next;
    logic          xfer_write_reg, xfer_write_next;
    logic          ret_idle_reg, ret_idle_next;   // ACK_TX returns to IDLE (write done) vs PAGE_WAIT
    logic [TW-1:0] timer_reg, timer_next;

    // Packet classification
    logic token_match;
    logic out_tok;
    logic in_tok;
    logic good_data;
    logic host_ack;

    always_comb begin
        token_match = bus.rx_valid && bus.rx_crc_ok &&
                      (bus.rx_addr == DEV_ADDR) && (bus.rx_endp == ENDP);
        out_tok     = token_match && (bus.rx_pid == PID_OUT);
        in_tok      = token_match && (bus.rx_pid == PID_IN);
        good_data   = bus.rx_valid && bus.rx_crc_ok && (bus.rx_pid == PID_DATA0);
        host_ack    = bus.rx_valid && bus.rx_crc_ok && (bus.rx_pid == PID_ACK);
    end

    // Next-state and output logic
    logic timer_run;
    logic accepted;

    always_comb begin
        state_next      = state_reg;
        page_next       = page_reg;
        tx_start_next   = 1'b0;
        tx_pid_next     = tx_pid_reg;
        // The read word is only valid on mem_rdata for one cycle; latch it
        // so tx_data stays stable for the rest of the transmit and retries.
        tx_data_next    = rd_capture_reg ? bus.mem_rdata : tx_data_reg;
        rd_capture_next = 1'b0;
        mem_rd_en_next  = 1'b0;
        mem_wr_en_next  = 1'b0;
        mem_wdata_next  = mem_wdata_reg;
        xfer_done_next  = 1'b0;
        xfer_write_next = 1'b0;
        ret_idle_next   = ret_idle_reg;
        timer_run       = 1'b0;
        accepted        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (out_tok) begin
                    state_next = CMD_DATA;
                end
            end

            CMD_DATA: begin
                timer_run = 1'b1;
                if (good_data) begin
                    accepted      = 1'b1;
                    page_next     = bus.rx_data[15:0];
                    tx_start_next = 1'b1;
                    tx_pid_next   = PID_ACK;
                    ret_idle_next = 1'b0;
                    state_next    = ACK_TX;
                end else if (out_tok) begin
                    accepted = 1'b1;           // host retry of the command token
                end
            end

            PAGE_WAIT: begin
                timer_run = 1'b1;
                if (in_tok) begin
                    accepted       = 1'b1;
                    mem_rd_en_next = 1'b1;
                    state_next     = RD_FETCH;
                end else if (out_tok) begin
                    accepted   = 1'b1;
                    state_next = WR_DATA;
                end
            end

            WR_DATA: begin
                timer_run = 1'b1;
                if (good_data) begin
                    accepted       = 1'b1;
                    mem_wr_en_next = 1'b1;
                    mem_wdata_next = bus.rx_data;
                    tx_start_next  = 1'b1;
                    tx_pid_next    = PID_ACK;
                    ret_idle_next  = 1'b1;
                    state_next     = ACK_TX;
                end else if (out_tok) begin
                    accepted = 1'b1;
                end
            end

            RD_FETCH: begin
                // mem_rdata lands next cycle, alongside tx_start
                tx_start_next   = 1'b1;
                tx_pid_next     = PID_DATA0;
                rd_capture_next = 1'b1;
                state_next      = RD_TX;
            end

            RD_TX: begin
                if (bus.tx_done) begin
                    state_next = RD_ACK;
                end
            end

            RD_ACK: begin
                timer_run = 1'b1;
                if (host_ack) begin
                    accepted       = 1'b1;
                    xfer_done_next = 1'b1;
                    state_next     = IDLE;
                end else if (in_tok) begin
                    // Host missed our DATA0: resend the held word, no new read
                    accepted      = 1'b1;
                    tx_start_next = 1'b1;
                    tx_pid_next   = PID_DATA0;
                    state_next    = RD_TX;
                end
            end

            ACK_TX: begin
                if (bus.tx_done) begin
                    if (ret_idle_reg) begin
                        xfer_done_next  = 1'b1;
                        xfer_write_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        state_next = PAGE_WAIT;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Idle-cycle watchdog for the wait states
        if (timer_run && !accepted && (timer_reg == TIMER_LAST)) begin
            state_next = IDLE;
        end

        // Clear on any state change or accepted packet; outside the wait
        // states (transmit pending) the count simply holds.
        if ((state_next != state_reg) || accepted) begin
            timer_next = '0;
        end else if (timer_run) begin
            timer_next = timer_reg + TW'(1);
        end else begin
            timer_next = timer_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg      <= IDLE;
            page_reg       <= '0;
            tx_start_reg   <= 1'b0;
            tx_pid_reg     <= '0;
            tx_data_reg    <= '0;
            rd_capture_reg <= 1'b0;
            mem_rd_en_reg  <= 1'b0;
            mem_wr_en_reg  <= 1'b0;
            mem_wdata_reg  <= '0;
            xfer_done_reg  <= 1'b0;
            xfer_write_reg <= 1'b0;
            ret_idle_reg   <= 1'b0;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            page_reg       <= page_next;
            tx_start_reg   <= tx_start_next;
            tx_pid_reg     <= tx_pid_next;
            tx_data_reg    <= tx_data_next;
            rd_capture_reg <= rd_capture_next;
            mem_rd_en_reg  <= mem_rd_en_next;
            mem_wr_en_reg  <= mem_wr_en_next;
            mem_wdata_reg  <= mem_wdata_next;
            xfer_done_reg  <= xfer_done_next;
            xfer_write_reg <= xfer_write_next;
            ret_idle_reg   <= ret_idle_next;
            timer_reg      <= timer_next;
        end
    end

    // Outputs. In the first DATA0 cycle the word comes straight from the
    // memory read port so the read latency stays at two cycles.
    assign bus.tx_start  = tx_start_reg;
    assign bus.tx_pid    = tx_pid_reg;
    assign bus.tx_data   = rd_capture_reg ? bus.mem_rdata : tx_data_reg;
    assign bus.mem_addr  = page_reg;
    assign bus.mem_rd_en = mem_rd_en_reg;
    assign bus.mem_wr_en = mem_wr_en_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign xfer_done     = xfer_done_reg;
    assign xfer_write    = xfer_write_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_usb_dev_rw_responder.sv
// ---------------------------------------------------------------------------
// tb_usb_dev_rw_responder
//
// Drives host-side packets into usb_dev_rw_responder, models the transmitter
// and a 64-bit memory, and compares the responder's behaviour with a
// page -> word dictionary that follows the protocol rules.
// ---------------------------------------------------------------------------
module tb_usb_dev_rw_responder;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [6:0] DADDR     = 7'd5;
    localparam logic [3:0] DENDP     = 4'd4;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    usb_dev_rw_responder_if bus();
    logic xfer_done;
    logic xfer_write;
    logic busy;

    usb_dev_rw_responder #(
        .DEV_ADDR (DADDR),
        .ENDP     (DENDP),
        .TIMEOUT  (255)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bus        (bus),
        .xfer_done  (xfer_done),
        .xfer_write (xfer_write),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Environment memory (registered read) plus a preload port
    logic [63:0] tb_mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [63:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)        tb_mem[pre_addr]     <= pre_data;
        if (bus.mem_wr_en) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata        <= tb_mem[bus.mem_addr];
    end

    // Reference model: what every page should hold
    logic [63:0] ref_mem [logic [15:0]];

    // Event counters
    int cnt_tx = 0;
    int cnt_rd = 0;
    int cnt_wr = 0;
    int cnt_done = 0;

    always @(posedge clk) begin
        if (rst_b) begin
            if (bus.tx_start)  cnt_tx   <= cnt_tx + 1;
            if (bus.mem_rd_en) cnt_rd   <= cnt_rd + 1;
            if (bus.mem_wr_en) cnt_wr   <= cnt_wr + 1;
            if (xfer_done)     cnt_done <= cnt_done + 1;
        end
    end

    // ---------------- stimulus primitives ----------------
    task automatic preload(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic [63:0] data,
                            input logic crc);
        @(negedge clk);
        bus.rx_valid  = 1'b1;
        bus.rx_pid    = pid;
        bus.rx_addr   = addr;
        bus.rx_endp   = endp;
        bus.rx_data   = data;
        bus.rx_crc_ok = crc;
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus.rx_crc_ok = 1'b0;
    endtask

    task automatic tx_finish();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    function automatic logic [63:0] page_payload(input logic [15:0] page);
        logic [31:0] hi;
        logic [15:0] mid;
        hi  = $urandom();
        mid = 16'($urandom());
        return {hi, mid, page};
    endfunction

    task automatic load_page(input logic [15:0] page, output logic acked);
        send_pkt(PID_OUT, DADDR, DENDP, 64'd0, 1'b1);
        send_pkt(PID_DATA0, 7'd0, 4'd0, page_payload(page), 1'b1);
        acked = bus.tx_start && (bus.tx_pid == PID_ACK);
        tx_finish();
    endtask

    // Full read transaction; returns what was observed
    task automatic run_read(input logic [15:0] page, output logic ack_ok,
                            output logic rd_ok, output logic start_ok,
                            output logic [63:0] got, output logic [63:0] got_end,
                            output logic done_ok);
        load_page(page, ack_ok);
        send_pkt(PID_IN, DADDR, DENDP, {$urandom(), $urandom()}, 1'b1);
        rd_ok = bus.mem_rd_en && (bus.mem_addr == page) && !bus.tx_start;
        @(negedge clk);
        start_ok = bus.tx_start && (bus.tx_pid == PID_DATA0);
        got = bus.tx_data;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        got_end = bus.tx_data;
        tx_finish();
        send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        done_ok = xfer_done && !xfer_write;
    endtask

    task automatic run_write(input logic [15:0] page, input logic [63:0] data,
                             output logic ack_page, output logic ack_wr,
                             output logic wr_ok, output logic done_ok);
        load_page(page, ack_page);
        send_pkt(PID_OUT, DADDR, DENDP, 64'd0, 1'b1);
        send_pkt(PID_DATA0, 7'd0, 4'd0, data, 1'b1);
        ack_wr = bus.tx_start && (bus.tx_pid == PID_ACK);
        wr_ok  = bus.mem_wr_en && (bus.mem_addr == page) && (bus.mem_wdata == data);
        tx_finish();
        done_ok = xfer_done && xfer_write;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [153:0] outs;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.tx_start, bus.tx_pid, bus.tx_data, bus.mem_addr, bus.mem_rd_en,
                bus.mem_wr_en, bus.mem_wdata, xfer_done, xfer_write, busy};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        outs = {bus.tx_start, bus.tx_pid, bus.tx_data, bus.mem_addr, bus.mem_rd_en,
                bus.mem_wr_en, bus.mem_wdata, xfer_done, xfer_write, busy};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h, expected 0", outs);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_read();
        logic a, r, s, d;
        logic [63:0] g, ge;
        int rd0;
        preload(16'h0042, 64'hDEADBEEF_01234567);
        rd0 = cnt_rd;
        run_read(16'h0042, a, r, s, g, ge, d);
        n_tests++;
        if (a !== 1'b1) begin n_fail++; $display("FAIL read_page_ack: got %0b, expected 1", a); end
        n_tests++;
        if (r !== 1'b1) begin n_fail++; $display("FAIL read_mem_rd: got %0b, expected 1", r); end
        n_tests++;
        if (s !== 1'b1) begin n_fail++; $display("FAIL read_data0_latency: got %0b, expected 1", s); end
        n_tests++;
        if (g !== ref_mem[16'h0042]) begin
            n_fail++; $display("FAIL read_data: got %h, expected %h", g, ref_mem[16'h0042]);
        end
        n_tests++;
        if (ge !== ref_mem[16'h0042]) begin
            n_fail++; $display("FAIL read_data_hold: got %h, expected %h", ge, ref_mem[16'h0042]);
        end
        n_tests++;
        if (d !== 1'b1) begin n_fail++; $display("FAIL read_xfer_done: got %0b, expected 1", d); end
        n_tests++;
        if (cnt_rd - rd0 !== 1) begin
            n_fail++; $display("FAIL read_count: got %0d, expected 1", cnt_rd - rd0);
        end
        $display("[TB] read page=0042 data=%h", g);
    endtask

    task automatic test_write();
        logic ap, aw, w, d, a, r, s, dr;
        logic [63:0] g, ge;
        int wr0;
        preload(16'h0010, 64'h1111_2222_3333_4444);
        wr0 = cnt_wr;
        run_write(16'h0010, 64'hA5A5_5A5A_0000_FFFF, ap, aw, w, d);
        ref_mem[16'h0010] = 64'hA5A5_5A5A_0000_FFFF;
        n_tests++;
        if ({ap, aw} !== 2'b11) begin
            n_fail++; $display("FAIL write_acks: got %b, expected 11", {ap, aw});
        end
        n_tests++;
        if (w !== 1'b1) begin n_fail++; $display("FAIL write_strobe: got %0b, expected 1", w); end
        n_tests++;
        if (d !== 1'b1) begin n_fail++; $display("FAIL write_xfer_done: got %0b, expected 1", d); end
        n_tests++;
        if (cnt_wr - wr0 !== 1) begin
            n_fail++; $display("FAIL write_count: got %0d, expected 1", cnt_wr - wr0);
        end
        run_read(16'h0010, a, r, s, g, ge, dr);
        n_tests++;
        if (g !== ref_mem[16'h0010]) begin
            n_fail++; $display("FAIL write_readback: got %h, expected %h", g, ref_mem[16'h0010]);
        end
        $display("[TB] write page=0010 data=%h", 64'hA5A5_5A5A_0000_FFFF);
    endtask

    task automatic test_bad_crc();
        int t0;
        preload(16'h0033, {$urandom(), $urandom()});
        t0 = cnt_tx;
        send_pkt(PID_OUT, DADDR, DENDP, 64'd0, 1'b1);
        send_pkt(PID_DATA0, 7'd0, 4'd0, 64'h0033, 1'b0);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({cnt_tx - t0 == 0, busy} !== 2'b11) begin
            n_fail++; $display("FAIL badcrc_dropped: got tx=%0d busy=%0b, expected tx=0 busy=1",
                               cnt_tx - t0, busy);
        end
        send_pkt(PID_DATA0, 7'd0, 4'd0, 64'h0033, 1'b1);
        n_tests++;
        if (!(bus.tx_start && bus.tx_pid == PID_ACK)) begin
            n_fail++; $display("FAIL badcrc_retry_ack: got start=%0b pid=%h, expected 1/2",
                               bus.tx_start, bus.tx_pid);
        end
        tx_finish();
        send_pkt(PID_IN, DADDR, DENDP, 64'd0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus.tx_data !== ref_mem[16'h0033]) begin
            n_fail++; $display("FAIL badcrc_read: got %h, expected %h", bus.tx_data, ref_mem[16'h0033]);
        end
        tx_finish();
        send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        n_tests++;
        if ({xfer_done, xfer_write} !== 2'b10) begin
            n_fail++; $display("FAIL badcrc_done: got %b, expected 10", {xfer_done, xfer_write});
        end
        $display("[TB] bad-crc retry page=0033");
    endtask

    task automatic test_wrong_addr();
        logic a;
        int r0, w0, t0;
        preload(16'h0077, {$urandom(), $urandom()});
        t0 = cnt_tx;
        send_pkt(PID_OUT, 7'd6, DENDP, 64'd0, 1'b1);
        send_pkt(PID_DATA0, 7'd0, 4'd0, 64'h0077, 1'b1);
        n_tests++;
        if ({busy, cnt_tx - t0 == 0} !== 2'b01) begin
            n_fail++; $display("FAIL wrong_addr_ignored: got busy=%0b tx=%0d, expected 0/0",
                               busy, cnt_tx - t0);
        end
        load_page(16'h0077, a);
        r0 = cnt_rd; w0 = cnt_wr;
        send_pkt(PID_IN, DADDR, 4'd3, 64'd0, 1'b1);
        send_pkt(PID_OUT, DADDR, 4'd3, 64'd0, 1'b1);
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cnt_rd - r0 == 0, cnt_wr - w0 == 0, busy} !== 3'b111) begin
            n_fail++; $display("FAIL wrong_endp_ignored: got rd=%0d wr=%0d busy=%0b, expected 0/0/1",
                               cnt_rd - r0, cnt_wr - w0, busy);
        end
        send_pkt(PID_IN, DADDR, DENDP, 64'd0, 1'b1);
        n_tests++;
        if (!(bus.mem_rd_en && bus.mem_addr == 16'h0077)) begin
            n_fail++; $display("FAIL wrong_endp_then_read: got rd=%0b addr=%h, expected 1/0077",
                               bus.mem_rd_en, bus.mem_addr);
        end
        tx_finish();
        send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        $display("[TB] wrong address/endpoint page=0077");
    endtask

    task automatic test_timeout();
        logic a;
        int d0, r0, t0;
        load_page(16'h0042, a);
        d0 = cnt_done;
        repeat (100) @(negedge clk);
        send_pkt(PID_IN, 7'd6, DENDP, 64'd0, 1'b1);   // non-matching: must not restart count
        repeat (148) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got busy=%0b, expected 1", busy); end
        repeat (10) @(negedge clk);
        n_tests++;
        if ({busy, cnt_done - d0 == 0} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_expired: got busy=%0b done=%0d, expected 0/0",
                               busy, cnt_done - d0);
        end
        r0 = cnt_rd; t0 = cnt_tx;
        send_pkt(PID_IN, DADDR, DENDP, 64'd0, 1'b1);
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cnt_rd - r0 == 0, cnt_tx - t0 == 0, busy} !== 3'b110) begin
            n_fail++; $display("FAIL timeout_late_in: got rd=%0d tx=%0d busy=%0b, expected 0/0/0",
                               cnt_rd - r0, cnt_tx - t0, busy);
        end
        $display("[TB] timeout page=0042");
    endtask

    task automatic test_read_retry_reset();
        logic a;
        int r0, t0, w0;
        logic [153:0] outs;
        preload(16'h0123, {$urandom(), $urandom()});
        r0 = cnt_rd;
        load_page(16'h0123, a);
        send_pkt(PID_IN, DADDR, DENDP, 64'd0, 1'b1);
        @(negedge clk);
        tx_finish();
        send_pkt(PID_IN, DADDR, DENDP, 64'd0, 1'b1);   // host retry
        n_tests++;
        if (!(bus.tx_start && bus.tx_pid == PID_DATA0 && bus.tx_data == ref_mem[16'h0123])) begin
            n_fail++; $display("FAIL retry_resend: got start=%0b data=%h, expected 1/%h",
                               bus.tx_start, bus.tx_data, ref_mem[16'h0123]);
        end
        tx_finish();
        send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        n_tests++;
        if ({xfer_done, xfer_write, cnt_rd - r0 == 1} !== 3'b101) begin
            n_fail++; $display("FAIL retry_done: got done=%0b wr=%0b reads=%0d, expected 1/0/1",
                               xfer_done, xfer_write, cnt_rd - r0);
        end
        $display("[TB] read retry page=0123 data=%h", ref_mem[16'h0123]);

        load_page(16'h0123, a);
        send_pkt(PID_IN, DADDR, DENDP, 64'd0, 1'b1);
        repeat (2) @(negedge clk);                      // now in RD_TX
        rst_b = 1'b0;
        #1;
        outs = {bus.tx_start, bus.tx_pid, bus.tx_data, bus.mem_addr, bus.mem_rd_en,
                bus.mem_wr_en, bus.mem_wdata, xfer_done, xfer_write, busy};
        n_tests++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_mid_read: got %h, expected 0", outs);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        t0 = cnt_tx; r0 = cnt_rd; w0 = cnt_wr;
        tx_finish();
        repeat (8) @(negedge clk);
        n_tests++;
        if ({cnt_tx - t0 == 0, cnt_rd - r0 == 0, cnt_wr - w0 == 0, busy} !== 4'b1110) begin
            n_fail++; $display("FAIL reset_quiet: got tx=%0d rd=%0d wr=%0d busy=%0b, expected 0/0/0/0",
                               cnt_tx - t0, cnt_rd - r0, cnt_wr - w0, busy);
        end
        $display("[TB] reset during read");
    endtask

    task automatic test_back_to_back();
        logic [15:0] pages [4];
        logic a, r, s, d, aw, w;
        logic [63:0] g, ge, data;
        int idx;
        for (int i = 0; i < 4; i++) begin
            pages[i] = 16'($urandom());
            preload(pages[i], {$urandom(), $urandom()});
        end
        for (int i = 0; i < 10; i++) begin
            idx = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                data = {$urandom(), $urandom()};
                run_write(pages[idx], data, a, aw, w, d);
                ref_mem[pages[idx]] = data;
                n_tests++;
                if ({a, aw, w, d} !== 4'b1111) begin
                    n_fail++; $display("FAIL b2b_write: got %b, expected 1111", {a, aw, w, d});
                end
                $display("[TB] b2b write page=%h data=%h", pages[idx], data);
            end else begin
                run_read(pages[idx], a, r, s, g, ge, d);
                n_tests++;
                if ({a, r, s, d} !== 4'b1111 || g !== ref_mem[pages[idx]]) begin
                    n_fail++; $display("FAIL b2b_read: got flags=%b data=%h, expected 1111/%h",
                                       {a, r, s, d}, g, ref_mem[pages[idx]]);
                end
                $display("[TB] b2b read page=%h data=%h", pages[idx], g);
            end
        end
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_pid    = '0;
        bus.rx_addr   = '0;
        bus.rx_endp   = '0;
        bus.rx_data   = '0;
        bus.rx_crc_ok = 1'b0;
        bus.tx_done   = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_bad_crc();
        test_wrong_addr();
        test_timeout();
        test_read_retry_reset();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
